vga_frame_ctrl: RTL and testbench

//  Upstream driver for the pattern generators: produces 640x480@60 VGA timing (x, y, hsync, vsync,

---
 rtl/vga_timing_pkg.sv | 55 +++++
 rtl/btn_debounce.sv | 77 +++++++
 rtl/vga_frame_ctrl.sv | 105 ++++++++++
 tb/tb_vga_frame_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// 640x480@60 VGA timing constants and rotation-step helpers, shared by
// vga_frame_ctrl and the pattern generators (SPEED_DEBOUNCE_EN has no effect here).
package vga_timing_pkg;

  localparam logic [9:0] H_VISIBLE = 10'd640;
  localparam logic [9:0] H_FP      = 10'd16;
  localparam logic [9:0] H_SYNC    = 10'd96;
  localparam logic [9:0] H_BP      = 10'd48;
  localparam logic [9:0] H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;

  localparam logic [9:0] V_VISIBLE = 10'd480;
  localparam logic [9:0] V_FP      = 10'd10;
  localparam logic [9:0] V_SYNC    = 10'd2;
  localparam logic [9:0] V_BP      = 10'd33;
  localparam logic [9:0] V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;

  // Inclusive sync windows and last count of each axis.
  localparam logic [9:0] H_SYNC_FIRST = H_VISIBLE + H_FP;
  localparam logic [9:0] H_SYNC_LAST  = H_SYNC_FIRST + H_SYNC - 10'd1;
  localparam logic [9:0] H_LAST       = H_TOTAL - 10'd1;
  localparam logic [9:0] V_SYNC_FIRST = V_VISIBLE + V_FP;
  localparam logic [9:0] V_SYNC_LAST  = V_SYNC_FIRST + V_SYNC - 10'd1;
  localparam logic [9:0] V_LAST       = V_TOTAL - 10'd1;

  localparam logic [9:0] H_CENTRE = H_VISIBLE >> 1;
  localparam logic [9:0] V_CENTRE = V_VISIBLE >> 1;

  localparam logic [2:0] STEP_MAX = 3'd7;

  typedef enum logic [1:0] {
    STEP_HOLD = 2'd0,
    STEP_INC  = 2'd1,
    STEP_DEC  = 2'd2
  } step_cmd_e;

  // Simultaneous up/down presses cancel out.
  function automatic step_cmd_e step_cmd(input logic up, input logic down);
    step_cmd = STEP_HOLD;
    if (up && !down) begin
      step_cmd = STEP_INC;
    end else if (down && !up) begin
      step_cmd = STEP_DEC;
    end
  endfunction

  function automatic logic [2:0] step_apply(input logic [2:0] cur, input step_cmd_e cmd);
    step_apply = cur;
    case (cmd)
      STEP_INC: if (cur != STEP_MAX) step_apply = cur + 3'd1;
      STEP_DEC: if (cur != 3'd0) step_apply = cur - 3'd1;
      default:  step_apply = cur;
    endcase
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw push-button to single-cycle rising-edge pulse: 2-flop synchronizer, then an
// optional stability filter (SPEED_DEBOUNCE_EN), then edge detect.
module btn_debounce #(
  parameter int DEB_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic rise_o
);

  logic sync1_q;
  logic sync2_q;
  logic level;
  logic prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
    end
  end

`ifdef SPEED_DEBOUNCE_EN
  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             level_q;
  logic             level_d;

  // The counter only runs while the input disagrees with the accepted level,
  // so any bounce back to the old value restarts the window.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level = level_q;
`else
  logic unused_deb_cfg;
  assign unused_deb_cfg = (DEB_CYCLES > 0);
  assign level = sync2_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= level;
    end
  end

  assign rise_o = level & ~prev_q;

endmodule

// File: rtl/vga_frame_ctrl.sv
// 640x480@60 timing generator plus button-controlled rotation step committed at
// frame boundaries. Define SPEED_DEBOUNCE_EN to filter the buttons over DEB_CYCLES clks.
module vga_frame_ctrl
  import vga_timing_pkg::*;
#(
  parameter int         DEB_CYCLES = 250000,
  parameter logic [2:0] STEP_RESET = 3'd1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       hsync,
  output logic       vsync,
  output logic       display_on,
  output logic       next_frame,
  output logic [2:0] step_size
);

  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       display_on_q, display_on_d;
  logic       next_frame_q, next_frame_d;
  logic [2:0] pending_q, pending_d;
  logic [2:0] step_q, step_d;

  logic [1:0] btn_raw;
  logic [1:0] btn_rise;
  step_cmd_e  cmd;

  assign btn_raw = {btn_down, btn_up};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_btn
      btn_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
      ) u_btn (
        .clk   (clk),
        .rst   (rst),
        .btn_i (btn_raw[gi]),
        .rise_o(btn_rise[gi])
      );
    end
  endgenerate

  always_comb begin
    x_d = x_q + 10'd1;
    y_d = y_q;
    if (x_q == H_LAST) begin
      x_d = '0;
      y_d = (y_q == V_LAST) ? '0 : y_q + 10'd1;
    end
  end

  // Flags are derived from the next counts so they line up with x/y in the same cycle.
  always_comb begin
    hsync_d      = ~((x_d >= H_SYNC_FIRST) && (x_d <= H_SYNC_LAST));
    vsync_d      = ~((y_d >= V_SYNC_FIRST) && (y_d <= V_SYNC_LAST));
    display_on_d = (x_d < H_VISIBLE) && (y_d < V_VISIBLE);
    next_frame_d = (x_d == 10'd0) && (y_d == V_VISIBLE);
  end

  // step_size picks up the pre-edge pending value when an edge lands on next_frame.
  always_comb begin
    cmd       = step_cmd(btn_rise[0], btn_rise[1]);
    pending_d = step_apply(pending_q, cmd);
    step_d    = next_frame_q ? pending_q : step_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q          <= '0;
      y_q          <= '0;
      hsync_q      <= 1'b1;
      vsync_q      <= 1'b1;
      display_on_q <= 1'b1;
      next_frame_q <= 1'b0;
      pending_q    <= STEP_RESET;
      step_q       <= STEP_RESET;
    end else begin
      x_q          <= x_d;
      y_q          <= y_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      display_on_q <= display_on_d;
      next_frame_q <= next_frame_d;
      pending_q    <= pending_d;
      step_q       <= step_d;
    end
  end

  assign x          = x_q;
  assign y          = y_q;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign display_on = display_on_q;
  assign next_frame = next_frame_q;
  assign step_size  = step_q;

endmodule

// File: tb/tb_vga_frame_ctrl.sv
// Directed bench for vga_frame_ctrl; jumps the raster counters to interesting
// positions so whole frames need not be simulated. Covers SPEED_DEBOUNCE_EN when defined.
`timescale 1ns/1ps
module tb_vga_frame_ctrl;

  localparam int DEB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic [9:0] x;
  logic [9:0] y;
  logic       hsync;
  logic       vsync;
  logic       display_on;
  logic       next_frame;
  logic [2:0] step_size;

  int n_total = 0;
  int n_bad = 0;
  logic [9:0] jx;
  logic [9:0] jy;

  vga_frame_ctrl #(
    .DEB_CYCLES(DEB),
    .STEP_RESET(3'd1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .x         (x),
    .y         (y),
    .hsync     (hsync),
    .vsync     (vsync),
    .display_on(display_on),
    .next_frame(next_frame),
    .step_size (step_size)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Park the raster so that x = xp+1, y = yp afterwards (xp < 799).
  task automatic jump(input logic [9:0] xp, input logic [9:0] yp);
    @(negedge clk);
    jx = xp;
    jy = yp;
    force dut.x_q = jx;
    force dut.y_q = jy;
    @(negedge clk);
    jx = xp + 10'd1;
    force dut.x_q = jx;
    force dut.y_q = jy;
    #1;
    release dut.x_q;
    release dut.y_q;
  endtask

  task automatic press(input logic up, input logic dn, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      btn_up = up;
      btn_down = dn;
      cyc(24);
      btn_up = 1'b0;
      btn_down = 1'b0;
      cyc(24);
    end
  endtask

  task automatic wait_nf(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (next_frame) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  // Run to the next frame boundary; check step_size during and after the strobe.
  task automatic commit(input string tag, input int during, input int after);
    bit seen;
    jump(10'd798, 10'd479);
    wait_nf(seen);
    chk({tag, "_nf_seen"}, int'(seen), 1);
    chk({tag, "_step_at_nf"}, int'(step_size), during);
    @(negedge clk);
    chk({tag, "_step_after"}, int'(step_size), after);
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  prev_x, wraps, x_err, y_err, hs_err, de_err, hs_low, de_cnt, nf_cnt, vs_low;
    int  de_fall_x, hs_fall_x, hs_rise_x, vs_fall_y, vs_rise_y;
    bit  prev_hs, prev_de, prev_vs, seen;
    int  p;

    // Reset state
    rst = 1'b1;
    cyc(3);
    chk("rst_x", int'(x), 0);
    chk("rst_y", int'(y), 0);
    chk("rst_hsync", int'(hsync), 1);
    chk("rst_vsync", int'(vsync), 1);
    chk("rst_display_on", int'(display_on), 1);
    chk("rst_next_frame", int'(next_frame), 0);
    chk("rst_step", int'(step_size), 1);
    chk("rst_pending", int'(dut.pending_q), 1);
    rst = 1'b0;

    // Two lines from reset: x wrap, hsync window, display_on boundary
    prev_x = int'(x);
    wraps = 0; x_err = 0; y_err = 0; hs_err = 0; de_err = 0;
    hs_low = 0; de_cnt = 0; nf_cnt = 0;
    de_fall_x = -1; hs_fall_x = -1; hs_rise_x = -1;
    prev_hs = 1'b1; prev_de = 1'b1;
    for (int i = 0; i < 1600; i++) begin
      @(negedge clk);
      if (int'(x) != ((prev_x == 799) ? 0 : prev_x + 1)) x_err++;
      if (prev_x == 799) begin
        wraps++;
        if (int'(y) != wraps) y_err++;
      end
      if (hsync != !(x >= 10'd656 && x <= 10'd751)) hs_err++;
      if (display_on != (x < 10'd640 && y < 10'd480)) de_err++;
      if (!hsync) hs_low++;
      if (display_on) de_cnt++;
      if (next_frame) nf_cnt++;
      if (prev_de && !display_on && de_fall_x < 0) de_fall_x = int'(x);
      if (prev_hs && !hsync && hs_fall_x < 0) hs_fall_x = int'(x);
      if (!prev_hs && hsync && hs_rise_x < 0) hs_rise_x = int'(x);
      prev_x = int'(x);
      prev_hs = hsync;
      prev_de = display_on;
    end
    chk("line_x_step_errors", x_err, 0);
    chk("line_x_wraps", wraps, 2);
    chk("line_y_errors", y_err, 0);
    chk("line_hsync_low_clks", hs_low, 192);
    chk("line_hsync_errors", hs_err, 0);
    chk("line_display_on_clks", de_cnt, 1280);
    chk("line_display_on_errors", de_err, 0);
    chk("line_de_fall_x", de_fall_x, 640);
    chk("line_hsync_fall_x", hs_fall_x, 656);
    chk("line_hsync_rise_x", hs_rise_x, 752);
    chk("line_next_frame_count", nf_cnt, 0);

    // Vertical sync window
    jump(10'd798, 10'd488);
    vs_low = 0; nf_cnt = 0; vs_fall_y = -1; vs_rise_y = -1; prev_vs = vsync;
    for (int i = 0; i < 3200; i++) begin
      @(negedge clk);
      if (!vsync) vs_low++;
      if (next_frame) nf_cnt++;
      if (prev_vs && !vsync && vs_fall_y < 0) vs_fall_y = int'(y);
      if (!prev_vs && vsync && vs_rise_y < 0) vs_rise_y = int'(y);
      prev_vs = vsync;
    end
    chk("vsync_low_clks", vs_low, 1600);
    chk("vsync_fall_y", vs_fall_y, 490);
    chk("vsync_rise_y", vs_rise_y, 492);
    chk("vsync_next_frame_count", nf_cnt, 0);

    // y wrap 524 -> 0
    jump(10'd797, 10'd524);
    @(negedge clk);
    chk("ywrap_pre_x", int'(x), 799);
    chk("ywrap_pre_de", int'(display_on), 0);
    @(negedge clk);
    chk("ywrap_x", int'(x), 0);
    chk("ywrap_y", int'(y), 0);
    chk("ywrap_de", int'(display_on), 1);
    chk("ywrap_vsync", int'(vsync), 1);

    // Last visible pixel, then next_frame at x=0,y=480
    jump(10'd638, 10'd479);
    chk("lastpix_de", int'(display_on), 1);
    @(negedge clk);
    chk("x640_de", int'(display_on), 0);
    wait_nf(seen);
    chk("nf_seen", int'(seen), 1);
    chk("nf_x", int'(x), 0);
    chk("nf_y", int'(y), 480);
    chk("nf_de", int'(display_on), 0);
    @(negedge clk);
    chk("nf_one_cycle", int'(next_frame), 0);

    // Up x8 saturates at 7, committed only at the frame boundary
    jump(10'd10, 10'd100);
    press(1'b1, 1'b0, 8);
    cyc(4);
    chk("up8_pending", int'(dut.pending_q), 7);
    chk("up8_step_mid_frame", int'(step_size), 1);
    commit("up8", 1, 7);

    // Down x9 saturates at 0, no wrap
    jump(10'd10, 10'd100);
    press(1'b0, 1'b1, 9);
    cyc(4);
    chk("dn9_pending", int'(dut.pending_q), 0);
    chk("dn9_step_mid_frame", int'(step_size), 7);
    commit("dn9", 7, 0);

    // Up x3, then a simultaneous press leaves pending unchanged
    jump(10'd10, 10'd100);
    press(1'b1, 1'b0, 3);
    cyc(4);
    chk("up3_pending", int'(dut.pending_q), 3);
    commit("up3", 0, 3);
    jump(10'd10, 10'd100);
    press(1'b1, 1'b1, 1);
    cyc(4);
    chk("both_pending", int'(dut.pending_q), 3);
    commit("both", 3, 3);

`ifndef SPEED_DEBOUNCE_EN
    // Button edge coincides with the next_frame cycle
    jump(10'd796, 10'd479);
    @(negedge clk);
    btn_up = 1'b1;
    cyc(2);
    chk("coin_nf", int'(next_frame), 1);
    chk("coin_step_at_nf", int'(step_size), 3);
    @(negedge clk);
    chk("coin_step_after", int'(step_size), 3);
    chk("coin_pending_after", int'(dut.pending_q), 4);
    btn_up = 1'b0;
    cyc(10);
    commit("coin_next", 3, 4);
`else
    // Bouncing press yields exactly one increment, 16 + 2 sync clks after the final edge
    jump(10'd10, 10'd100);
    p = int'(dut.pending_q);
    for (int s = 0; s < 8; s++) begin
      btn_up = (s % 2 == 0);
      cyc(5);
    end
    chk("deb_bounce_pending", int'(dut.pending_q), p);
    btn_up = 1'b1;
    for (int k = 1; k <= 19; k++) begin
      @(negedge clk);
      if (k == 18) chk("deb_pending_at_18", int'(dut.pending_q), p);
      if (k == 19) chk("deb_pending_at_19", int'(dut.pending_q), p + 1);
    end
    cyc(10);
    btn_up = 1'b0;
    cyc(30);
    chk("deb_pending_final", int'(dut.pending_q), p + 1);
`endif

    // Asynchronous reset mid-frame, then a clean restart
    jump(10'd298, 10'd200);
    @(negedge clk);
    chk("mid_x_before_rst", int'(x), 300);
    rst = 1'b1;
    #1;
    chk("midrst_x", int'(x), 0);
    chk("midrst_y", int'(y), 0);
    chk("midrst_hsync", int'(hsync), 1);
    chk("midrst_vsync", int'(vsync), 1);
    chk("midrst_de", int'(display_on), 1);
    chk("midrst_step", int'(step_size), 1);
    chk("midrst_pending", int'(dut.pending_q), 1);
    @(negedge clk);
    rst = 1'b0;
    prev_x = 0; x_err = 0; hs_low = 0;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      if (int'(x) != ((prev_x == 799) ? 0 : prev_x + 1)) x_err++;
      if (!hsync) hs_low++;
      prev_x = int'(x);
    end
    chk("restart_x_errors", x_err, 0);
    chk("restart_hsync_low", hs_low, 96);
    chk("restart_y", int'(y), 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
